mm_ram_slave: RTL and testbench
===============================

# mm_ram_slave

Pipelined memory-mapped RAM slave that sits directly downstream of the MM-to-stream arbiter, consuming its `o_addr`/`o_read`/`o_write`/`o_writedata` and driving its `i_readdata`/`i_readdatavalid`/`i_waitrequest`. It models on-chip data memory with:

- a fixed read latency,
- a bounded number of outstanding reads,
- optional periodic busy injection, so the arbiter's waitrequest and out-of-phase readdatavalid paths are exercised.

## Interface
- `p_data_bits`, default `WORD_BITS` (32): data word width.
- `p_addr_bits`, default `MEM_ADDR_BITS` (18): address port width, word addressing.
- `p_depth_log2`, default 10: RAM holds 2^p_depth_log2 words; decoding uses `i_addr[p_depth_log2-1:0]`, upper bits ignored.
- `p_read_latency`, default 3: cycles from read accept to readdatavalid; legal range 1..8.
- `p_max_outstanding`, default 4: read limit; legal range 1..15.
- `p_busy_period`, default 0: 0 disables busy injection; N>=2 forces one busy cycle every N cycles.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `i_addr` in p_addr_bits: word address.
- `i_writedata` in p_data_bits: write data.
- `i_write` in 1: write request.
- `i_read` in 1: read request.
- `o_waitrequest` out 1: command not accepted this cycle; master must hold its command.
- `o_readdata` out p_data_bits: read data, valid only with `o_readdatavalid`.
- `o_readdatavalid` out 1: one-cycle strobe per accepted read, in request order.

## Operation
- **Accept:** a command is accepted on a rising edge where (`i_read` | `i_write`) & !`o_waitrequest`. At most one command is accepted per cycle.
- **Read and write together:** the write is performed and the read is dropped. No readdatavalid is produced for the dropped read.
- **Write:** the RAM word is updated at the accept edge. A read accepted on any later edge returns the new value.
- **Read:** RAM is sampled at the accept edge, and the data plus a valid bit enter a shift pipeline of p_read_latency stages. The last stage drives `o_readdata`/`o_readdatavalid` directly from flops.
- **Outstanding counter:**
  - +1 on read accept.
  - −1 on each cycle with `o_readdatavalid` = 1.
  - Unchanged when both happen on the same edge.
  - Never exceeds p_max_outstanding and never goes below 0.
- **Waitrequest:** `o_waitrequest` = !rst | (outstanding == p_max_outstanding) | busy_slot. It is combinational from registered state only, with no path from `i_read`/`i_write`.
- **Busy slot:** a free-running counter runs modulo p_busy_period. busy_slot = 1 when counter == p_busy_period−1; it is always 0 when p_busy_period = 0.
- **Stall scope:** waitrequest stalls writes as well as reads, including when the stall is caused by the outstanding limit.
- **Reset (rst=0, asynchronous):**
  - Cleared to 0: pipeline valid bits, pipeline data, `o_readdata`, `o_readdatavalid`, outstanding counter, busy counter.
  - `o_waitrequest` = 1.
  - RAM contents are not reset.
  - Reset mid-operation discards in-flight reads; no readdatavalid is emitted for them after release.

## Timing
- **Read latency:** read accepted at edge T → `o_readdatavalid` = 1 for exactly the cycle following edge T+p_read_latency−1.
  - With L=1, valid is seen in the cycle right after the accept edge.
  - Back-to-back accepts give back-to-back valids.
- **Throughput:** with p_max_outstanding >= p_read_latency and busy disabled, `o_waitrequest` stays 0 and one read per cycle is sustained.
- **Limit reached:** with p_max_outstanding < p_read_latency, waitrequest rises the cycle after the limit-reaching accept. It falls in the same cycle that readdatavalid is high, so a new read can be accepted on that edge.
- **Reset release:** first accept possible on the first rising edge after rst deasserts, provided the busy and limit conditions are clear.

## Structure
- Width constants `WORD_BITS` and `MEM_ADDR_BITS` come from the shared define file; no new shared typedefs.
- One sub-module, `read_delay_pipe`: a parameterised valid+data shift register (depth p_read_latency, async active-low reset).
- RAM, accept logic, outstanding counter and busy counter are in the top module.

## Test plan
- **Write then read:** write 0xDEADBEEF to addr 5, then read addr 5 on the next cycle (L=3) → readdatavalid exactly 3 cycles after the read accept, data 0xDEADBEEF, waitrequest never high.
- **Streaming reads:** 8 consecutive reads of addr 0..7 preloaded with 0x100+i (L=3, max=4) → 8 consecutive valids carrying 0x100..0x107 in order.
- **Outstanding limit:** L=4, max=2, continuous reads.
  - Waitrequest goes high after the 2nd accept.
  - Each later accept coincides with a valid.
  - Sustained rate is 2 reads per 4 cycles; the outstanding count never exceeds 2.
- **Busy injection:** p_busy_period=4 with continuous writes.
  - Waitrequest is high every 4th cycle.
  - The held write is accepted on the next cycle, and each write lands exactly once.
  - Readback matches.
- **Simultaneous read and write:** `i_read` = `i_write` = 1, addr 9, data 0x55 → no readdatavalid is produced; a later read of addr 9 returns 0x55.
- **Reset mid-read:** assert rst while 3 reads are in flight.
  - Outputs go to 0 and `o_waitrequest` goes to 1 immediately.
  - After release, no stale valids appear and the outstanding count is 0.

Source files
------------

// File: rtl/mm_ram_slave_pkg.sv
// Shared width constants and small elaboration helpers for the memory-mapped RAM slave.
package mm_ram_slave_pkg;

  localparam int WORD_BITS     = 32;
  localparam int MEM_ADDR_BITS = 18;

  // Outstanding-read counter is sized for the largest legal read limit (15).
  localparam int OUTST_BITS = 4;

  function automatic int busy_cnt_bits(input int period);
    return (period < 2) ? 1 : $clog2(period);
  endfunction

endpackage

// File: rtl/mm_ram_slave_read_delay_pipe.sv
// Valid+data shift register: p_depth cycles from input to flopped output.
// No backpressure; every entry advances one stage per clock.
module read_delay_pipe #(
  parameter int p_data_bits = 32,
  parameter int p_depth     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld,
  input  logic [p_data_bits-1:0] in_dat,
  output logic                   out_vld,
  output logic [p_data_bits-1:0] out_dat
);

  logic [p_depth-1:0]                  vld_q;
  logic [p_depth-1:0][p_data_bits-1:0] dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      dat_q[0] <= in_dat;
      for (int i = 1; i < p_depth; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[p_depth-1];
  assign out_dat = dat_q[p_depth-1];

endmodule

// File: rtl/mm_ram_slave.sv
// On-chip RAM slave: fixed read latency, bounded outstanding reads, optional busy slots.
// Waitrequest derives only from reset and registered state; stalls reads and writes alike.
module mm_ram_slave
  import mm_ram_slave_pkg::*;
#(
  parameter int p_data_bits       = WORD_BITS,
  parameter int p_addr_bits       = MEM_ADDR_BITS,
  parameter int p_depth_log2      = 10,
  parameter int p_read_latency    = 3,
  parameter int p_max_outstanding = 4,
  parameter int p_busy_period     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [p_addr_bits-1:0] i_addr,
  input  logic [p_data_bits-1:0] i_writedata,
  input  logic                   i_write,
  input  logic                   i_read,
  output logic                   o_waitrequest,
  output logic [p_data_bits-1:0] o_readdata,
  output logic                   o_readdatavalid
);

  localparam int DEPTH = 1 << p_depth_log2;
  localparam int BW    = busy_cnt_bits(p_busy_period);

  logic [p_data_bits-1:0]  mem [DEPTH];
  logic [p_depth_log2-1:0] word_addr;
  logic                    unused_addr_hi;

  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [p_data_bits-1:0]  rd_dat;

  logic [OUTST_BITS-1:0]   outst_q;
  logic                    at_limit;
  logic [BW-1:0]           busy_q;
  logic                    busy_slot;

  assign word_addr      = i_addr[p_depth_log2-1:0];
  assign unused_addr_hi = ^i_addr[p_addr_bits-1:p_depth_log2];

  // A returning read frees its slot in the same cycle, so the limit only
  // stalls when no readdatavalid is leaving the pipe.
  assign at_limit  = (outst_q == OUTST_BITS'(p_max_outstanding)) && !o_readdatavalid;
  assign busy_slot = (p_busy_period >= 2) && (busy_q == BW'(p_busy_period - 1));

  assign o_waitrequest = !rst || at_limit || busy_slot;

  assign accept = (i_read || i_write) && !o_waitrequest;
  assign wr_acc = accept && i_write;
  assign rd_acc = accept && i_read && !i_write;
  assign rd_dat = rd_acc ? mem[word_addr] : '0;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[word_addr] <= i_writedata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst_q <= '0;
    end else if (rd_acc && !o_readdatavalid) begin
      outst_q <= outst_q + OUTST_BITS'(1);
    end else if (!rd_acc && o_readdatavalid) begin
      outst_q <= outst_q - OUTST_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else if (p_busy_period < 2 || busy_slot) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_q + BW'(1);
    end
  end

  read_delay_pipe #(
    .p_data_bits (p_data_bits),
    .p_depth     (p_read_latency)
  ) u_read_delay_pipe (
    .clk     (clk),
    .rst_n   (rst),
    .in_vld  (rd_acc),
    .in_dat  (rd_dat),
    .out_vld (o_readdatavalid),
    .out_dat (o_readdata)
  );

endmodule

// File: tb/tb_mm_ram_slave.sv
// Scoreboard bench: three slave configurations (L3/max4, L4/max2, L3/max4/busy4).
module tb_mm_ram_slave;

  logic                  clk;
  logic [2:0]            rst_v, rd_v, wr_v, wreq_v, rvld_v;
  logic [2:0][17:0]      addr_v;
  logic [2:0][31:0]      wdat_v, rdat_v;

  int cyc = 0;
  int since_rst [3] = '{0, 0, 0};
  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t        q0[$], q1[$], q2[$];
  logic [31:0] mdl [3][64];

  int acc [8];
  int a0, a1, w0, w1, nw, nwsum, rel;
  int lim_off [8] = '{0, 1, 4, 5, 8, 9, 12, 13};

  mm_ram_slave #(.p_read_latency(3), .p_max_outstanding(4), .p_busy_period(0)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .i_addr(addr_v[0]), .i_writedata(wdat_v[0]),
    .i_write(wr_v[0]), .i_read(rd_v[0]), .o_waitrequest(wreq_v[0]),
    .o_readdata(rdat_v[0]), .o_readdatavalid(rvld_v[0]));

  mm_ram_slave #(.p_read_latency(4), .p_max_outstanding(2), .p_busy_period(0)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .i_addr(addr_v[1]), .i_writedata(wdat_v[1]),
    .i_write(wr_v[1]), .i_read(rd_v[1]), .o_waitrequest(wreq_v[1]),
    .o_readdata(rdat_v[1]), .o_readdatavalid(rvld_v[1]));

  mm_ram_slave #(.p_read_latency(3), .p_max_outstanding(4), .p_busy_period(4)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .i_addr(addr_v[2]), .i_writedata(wdat_v[2]),
    .i_write(wr_v[2]), .i_read(rd_v[2]), .o_waitrequest(wreq_v[2]),
    .o_readdata(rdat_v[2]), .o_readdatavalid(rvld_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) since_rst[k] <= rst_v[k] ? since_rst[k] + 1 : 0;
  end

  function automatic int lat(input int k);
    return (k == 1) ? 4 : 3;
  endfunction

  function automatic int maxo(input int k);
    return (k == 1) ? 2 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Holds the command until accepted; acc is the cycle number of the accept edge.
  task automatic cmd(input int k, input bit rd, input bit wr, input int a,
                     input logic [31:0] d, output int acc_c, output int waits);
    exp_t e;
    rd_v[k]   = rd;
    wr_v[k]   = wr;
    addr_v[k] = 18'(a);
    wdat_v[k] = d;
    waits     = 0;
    acc_c     = -1;
    #1;
    while (wreq_v[k] && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    if (wreq_v[k]) begin
      chk("cmd_timeout", 32'(wreq_v[k]), 32'd0);
    end else begin
      @(posedge clk);
      #1;
      acc_c = cyc;
      if (wr) begin
        mdl[k][a] = d;
      end else if (rd) begin
        e.d = mdl[k][a];
        e.c = cyc + lat(k) - 1;
        qpush(k, e);
      end
    end
    rd_v[k] = 1'b0;
    wr_v[k] = 1'b0;
  endtask

  task automatic mon(input int k);
    exp_t e;
    if (rst_v[k]) begin
      if (k == 2) chk("busy_wreq", 32'(wreq_v[2]), 32'(since_rst[2] % 4 == 3));
      if (rvld_v[k]) begin
        if (qsize(k) == 0) begin
          chk("unexpected_vld", 32'(rvld_v[k]), 32'd0);
        end else begin
          chk("outstanding_le_max", 32'(qsize(k) <= maxo(k)), 32'd1);
          qpop(k, e);
          chk("rdata", rdat_v[k], e.d);
          chk("rd_latency", 32'(cyc), 32'(e.c));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) mon(k);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v  = '0;
    rd_v   = '0;
    wr_v   = '0;
    addr_v = '0;
    wdat_v = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_wreq",  32'(wreq_v[k]), 32'd1);
      chk("rst_vld",   32'(rvld_v[k]), 32'd0);
      chk("rst_rdata", rdat_v[k],      32'd0);
    end
    #2;
    rst_v = '1;
    rel   = cyc;

    // Write then read on consecutive cycles, first accept right after release.
    cmd(0, 1'b0, 1'b1, 5, 32'hDEADBEEF, a0, w0);
    chk("first_accept", 32'(a0), 32'(rel + 1));
    cmd(0, 1'b1, 1'b0, 5, 32'h0, a1, w1);
    chk("wr_rd_b2b", 32'(a1), 32'(a0 + 1));
    chk("wr_rd_nowait", 32'(w0 + w1), 32'd0);
    repeat (6) @(negedge clk);

    // Streaming reads at one per cycle.
    for (int i = 0; i < 8; i++) cmd(0, 1'b0, 1'b1, i, 32'h100 + i, acc[i], nw);
    for (int i = 0; i < 8; i++) cmd(0, 1'b1, 1'b0, i, 32'h0, acc[i], nw);
    for (int i = 0; i < 8; i++) chk("stream_acc", 32'(acc[i] - acc[0]), 32'(i));
    repeat (6) @(negedge clk);

    // Read+write together: write lands, read is dropped.
    cmd(0, 1'b1, 1'b1, 9, 32'h55, a0, nw);
    repeat (6) @(negedge clk);
    cmd(0, 1'b1, 1'b0, 9, 32'h0, a0, nw);
    repeat (6) @(negedge clk);

    // Reset with reads in flight.
    for (int i = 0; i < 3; i++) cmd(0, 1'b1, 1'b0, i, 32'h0, acc[i], nw);
    rst_v[0] = 1'b0;
    q0.delete();
    #1;
    chk("midrst_vld",   32'(rvld_v[0]), 32'd0);
    chk("midrst_rdata", rdat_v[0],      32'd0);
    chk("midrst_wreq",  32'(wreq_v[0]), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_v[0] = 1'b1;
    repeat (8) @(negedge clk);
    nwsum = 0;
    for (int i = 0; i < 4; i++) begin
      cmd(0, 1'b1, 1'b0, i, 32'h0, acc[i], nw);
      nwsum += nw;
    end
    for (int i = 1; i < 4; i++) chk("postrst_acc", 32'(acc[i] - acc[0]), 32'(i));
    chk("postrst_nowait", 32'(nwsum), 32'd0);

    // Outstanding limit: L=4, max=2.
    for (int i = 0; i < 8; i++) cmd(1, 1'b0, 1'b1, i, 32'h200 + i, acc[i], nw);
    for (int i = 0; i < 8; i++) begin
      cmd(1, 1'b1, 1'b0, i, 32'h0, acc[i], nw);
      if (i == 1) chk("limit_wreq_hi", 32'(wreq_v[1]), 32'd1);
    end
    for (int i = 0; i < 8; i++) chk("limit_acc", 32'(acc[i] - acc[0]), 32'(lim_off[i]));

    // Busy injection every 4th cycle: writes, then readback.
    for (int i = 0; i < 8; i++) cmd(2, 1'b0, 1'b1, 20 + i, 32'hA0 + i, acc[i], nw);
    for (int i = 1; i < 8; i++)
      chk("busy_gap", 32'((acc[i] - acc[i-1] == 1) || (acc[i] - acc[i-1] == 2)), 32'd1);
    for (int i = 0; i < 8; i++) cmd(2, 1'b1, 1'b0, 20 + i, 32'h0, acc[i], nw);

    repeat (12) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("queue_drained", 32'(qsize(k)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
